// File: rtl/cnt_share_ctrl.sv
// Round-robin arbiter and sequencer for a single shared up-counter.
// Grants one requester, clears the counter, runs it to the latched length, then pulses done.
module cnt_share_ctrl #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] req_len,
  input  logic [CW-1:0]   cnt_in,
  output logic          ctr_rst,
  output logic          ctr_en,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic          err,
  output logic          busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

  state_e        state_q;
  logic [PW-1:0] rr_ptr_q;
  logic [CW-1:0] len_q;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  done_q;
  logic          err_q;
  logic          ctr_rst_q;
  logic          busy_q;

  logic          found;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [PW-1:0] next_ptr;
  int            idx;

  // Scan rr_ptr, rr_ptr+1, ... (mod N); the first set request wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
    win_oh   = N'(1) << win_idx;
    next_ptr = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      len_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      ctr_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      ctr_rst_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q   <= CLEAR;
            gnt_q     <= win_oh;
            len_q     <= req_len[int'(win_idx)*CW +: CW];
            rr_ptr_q  <= next_ptr;
            ctr_rst_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: state_q <= RUN;
        RUN: begin
          // Equal completes normally; anything beyond the length is an overshoot.
          if (cnt_in >= len_q) begin
            state_q <= DONE;
            done_q  <= gnt_q;
            err_q   <= (cnt_in > len_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctr_en  = (state_q == RUN) && (cnt_in < len_q);
  assign ctr_rst = ctr_rst_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_cnt_share_ctrl.sv
// Self-checking bench for cnt_share_ctrl with a shared-counter model and a
// transaction-level round-robin/timing reference.
module tb_cnt_share_ctrl;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_len;
  logic [CW-1:0]   cnt_in;
  logic          ctr_rst, ctr_en, err, busy;
  logic [N-1:0]    gnt, done;

  cnt_share_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .cnt_in(cnt_in),
    .ctr_rst(ctr_rst), .ctr_en(ctr_en), .gnt(gnt), .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared counter; tamper overrides what the controller sees.
  logic [CW-1:0] cnt_q = '0;
  logic          tamper = 1'b0;
  logic [CW-1:0] tamper_val = '0;
  always @(posedge clk) begin
    if (ctr_rst)     cnt_q <= '0;
    else if (ctr_en) cnt_q <= cnt_q + 1'b1;
  end
  assign cnt_in = tamper ? tamper_val : cnt_q;

  int n_cmp = 0;
  int n_mis = 0;
  int model_ptr = 0;
  int len_tab[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic load_lens();
    for (int i = 0; i < N; i++) req_len[i*CW +: CW] = CW'(len_tab[i]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_ctr_rst"}, 32'(ctr_rst), 0);
    check({tag, "_ctr_en"}, 32'(ctr_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Called at a negedge while the controller is in IDLE; returns in the IDLE cycle after DONE.
  // tamper_at > 0 forces cnt_in above the length from that cycle (0 = CLEAR, 1.. = RUN).
  task automatic run_txn(input logic [N-1:0] r, input int drop_after, input int tamper_at,
                         input string tag);
    int w, L, c, n_en, n_gnt, n_rst, n_bad, n_extra, done_c;
    int exp_en, exp_done_c, exp_err;
    logic [N-1:0] exp_g, done_v;
    logic err_at, reached;
    req = r;
    load_lens();
    w = rr_pick(r, model_ptr);
    exp_g = N'(1) << w;
    L = len_tab[w];
    model_ptr = (w + 1) % N;
    if (tamper_at > 0) begin
      exp_en = tamper_at - 1; exp_done_c = tamper_at + 1; exp_err = 1;
    end else begin
      exp_en = L; exp_done_c = L + 2; exp_err = 0;
    end
    n_en = 0; n_gnt = 0; n_rst = 0; n_bad = 0; n_extra = 0;
    done_c = -1; done_v = '0; err_at = 1'b0; reached = 1'b0;
    @(posedge clk);
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tamper_at > 0 && c == tamper_at) begin
        tamper_val = CW'(L + 3);
        tamper = 1'b1;
      end
      if (c == drop_after) req = '0;
      if (c == 1) req_len = (N*CW)'($urandom);
      #1;
      if (c == 0) begin
        check({tag, "_clear_ctr_rst"}, 32'(ctr_rst), 1);
        check({tag, "_clear_gnt"}, 32'(gnt), 32'(exp_g));
        check({tag, "_clear_busy"}, 32'(busy), 1);
      end
      if (ctr_rst) n_rst++;
      if (ctr_en) n_en++;
      if (gnt == exp_g) n_gnt++;
      else if (gnt != '0) n_bad++;
      if (done != '0) begin
        if (done_c < 0) begin
          done_c = c; done_v = done; err_at = err;
        end else n_extra++;
      end else if (err) n_extra++;
      if (done_c >= 0 && c == done_c + 1) begin
        check({tag, "_idle_gnt"}, 32'(gnt), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        reached = 1'b1;
        break;
      end
    end
    tamper = 1'b0;
    check({tag, "_completed_in_budget"}, 32'(reached), 1);
    check({tag, "_gnt_cycles"}, n_gnt, exp_done_c + 1);
    check({tag, "_en_cycles"}, n_en, exp_en);
    check({tag, "_rst_cycles"}, n_rst, 1);
    check({tag, "_foreign_gnt"}, n_bad, 0);
    check({tag, "_done_cycle"}, done_c, exp_done_c);
    check({tag, "_done_val"}, 32'(done_v), 32'(exp_g));
    check({tag, "_err_at_done"}, 32'(err_at), exp_err);
    check({tag, "_stray_pulses"}, n_extra, 0);
    check({tag, "_final_cnt"}, 32'(cnt_q), exp_en);
  endtask

  task automatic reset_mid_run();
    logic hit;
    for (int i = 0; i < N; i++) len_tab[i] = 10;
    load_lens();
    req = 4'b0100;
    hit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (cnt_in == CW'(4)) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_reached_cnt4", 32'(hit), 1);
    check("rst_mid_busy_before", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("rst_mid_async");
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    #1;
    check("rst_mid_busy_after", 32'(busy), 0);
    check("rst_mid_cnt_held", 32'(cnt_q), 4);
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_len = '0;
    #3;
    check_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_busy", 32'(busy), 0);

    for (int i = 0; i < N; i++) len_tab[i] = 7;
    len_tab[1] = 5;
    run_txn(4'b0010, -1, 0, "single");

    req = '0;
    repeat (2) @(negedge clk);
    #1;
    check("idle_no_req_busy", 32'(busy), 0);
    check("idle_no_req_gnt", 32'(gnt), 0);

    reset_mid_run();

    for (int i = 0; i < N; i++) len_tab[i] = 2;
    for (int t = 0; t < 5; t++) run_txn(4'b1111, -1, 0, $sformatf("rr%0d", t));

    len_tab[0] = 0;
    run_txn(4'b0001, -1, 0, "zero_len");

    len_tab[3] = 6;
    run_txn(4'b1000, -1, 4, "overshoot");

    len_tab[2] = 255;
    run_txn(4'b0100, 3, 0, "maxlen_drop");

    for (int t = 0; t < 25; t++) begin
      logic [N-1:0] r;
      int tam, drop, li;
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) len_tab[i] = $urandom_range(0, 12);
      li = rr_pick(r, model_ptr);
      tam = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len_tab[li] + 1) : 0;
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : -1;
      run_txn(r, drop, tam, $sformatf("rand%0d", t));
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
        check($sformatf("rand%0d_gap_busy", t), 32'(busy), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
